// File: rtl/otp_ctrl_prog_arb.sv
// OTP programming arbiter: shares one OTP macro interface between the
// lifecycle interface (port 0) and the direct access interface (port 1).
// At most one macro transaction is in flight; ties are broken round-robin.
// Widths mirror the OTP controller packages: size 2b, interface word 64b,
// halfword address 10b, scramble block 64b, lc_tx_t 4b, cmd/err 3b.
module otp_ctrl_prog_arb (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [3:0]       escalate_en_i,
    // per-port request bundles (index 0 = LCI, index 1 = DAI)
    input  logic [1:0]       req_i,
    input  logic [1:0][2:0]  cmd_i,
    input  logic [1:0][1:0]  size_i,
    input  logic [1:0][63:0] wdata_i,
    input  logic [1:0][9:0]  addr_i,
    output logic [1:0]       gnt_o,
    output logic [1:0]       rvalid_o,
    output logic [63:0]      rdata_o,
    output logic [2:0]       err_o,
    // macro request bundle
    output logic             otp_req_o,
    output logic [2:0]       otp_cmd_o,
    output logic [1:0]       otp_size_o,
    output logic [63:0]      otp_wdata_o,
    output logic [9:0]       otp_addr_o,
    // macro response
    input  logic             otp_gnt_i,
    input  logic             otp_rvalid_i,
    input  logic [63:0]      otp_rdata_i,
    input  logic [2:0]       otp_err_i,
    output logic             fsm_err_o,
    output logic             idle_o
);

    // lc_tx_t "Off"; any other value counts as escalation (loose true)
    localparam logic [3:0] LcTxOff = 4'b1010;
    localparam logic [2:0] CmdRead = 3'h0;
    localparam logic [2:0] ErrNone = 3'h0;

    // Sparse encoding, pairwise Hamming distance >= 5: each state is a 2-bit
    // code with every bit repeated five times, XORed with a fixed mask so no
    // state is all-zeros or all-ones.
    typedef enum logic [9:0] {
        IdleSt    = 10'b1011001101,
        WaitGntSt = 10'b1011010010,
        WaitRspSt = 10'b0100101101,
        ErrorSt   = 10'b0100110010
    } state_e;

    state_e state_d, state_q;
    logic   owner_d, owner_q;   // port owning the outstanding transaction
    logic   ptr_d, ptr_q;       // port preferred on the next tie
    logic   fwd_en;             // forward a request bundle to the macro
    logic   fwd_sel;            // which port's bundle is forwarded
    logic   winner;             // arbitration result in IdleSt
    logic   escalate;

    // Next-state, arbitration and per-port response decode
    always_comb begin
        // NOTE: every output of this block gets a default first, otherwise a
        // path that skips an assignment would infer a latch.
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        fwd_en    = 1'b0;
        fwd_sel   = owner_q;
        gnt_o     = '0;
        rvalid_o  = '0;
        rdata_o   = '0;
        err_o     = ErrNone;
        fsm_err_o = 1'b0;
        idle_o    = 1'b0;

        // Port 1 wins when it is the sole requester, or on a tie when the
        // pointer prefers it; otherwise port 0 wins.
        winner   = req_i[1] & (~req_i[0] | ptr_q);
        escalate = (escalate_en_i != LcTxOff);

        case (state_q)
            IdleSt: begin
                idle_o = ~|req_i;
                if (otp_rvalid_i) begin
                    // Response with nothing outstanding: protocol violation.
                    state_d   = ErrorSt;
                    fsm_err_o = 1'b1;
                end else if (|req_i) begin
                    fwd_en  = 1'b1;
                    fwd_sel = winner;
                    owner_d = winner;
                    if (otp_gnt_i) begin
                        gnt_o[winner] = 1'b1;
                        ptr_d         = ~winner;
                        state_d       = WaitRspSt;
                    end else begin
                        state_d = WaitGntSt;
                    end
                end
            end
            WaitGntSt: begin
                if (otp_rvalid_i || !req_i[owner_q]) begin
                    // Early response or owner withdrew its held request.
                    state_d   = ErrorSt;
                    fsm_err_o = 1'b1;
                end else begin
                    fwd_en = 1'b1;
                    if (otp_gnt_i) begin
                        gnt_o[owner_q] = 1'b1;
                        ptr_d          = ~owner_q;
                        state_d        = WaitRspSt;
                    end
                end
            end
            WaitRspSt: begin
                if (otp_rvalid_i) begin
                    rvalid_o[owner_q] = 1'b1;
                    rdata_o           = otp_rdata_i;
                    err_o             = otp_err_i;
                    state_d           = IdleSt;
                end
            end
            ErrorSt: begin
                // Terminal: everything stays quiet until reset.
            end
            default: begin
                state_d   = ErrorSt;
                fsm_err_o = 1'b1;
            end
        endcase

        // Escalation wins over anything decoded above, including a
        // coincident grant or response.
        if (escalate) begin
            state_d   = ErrorSt;
            fsm_err_o = 1'b1;
            fwd_en    = 1'b0;
            gnt_o     = '0;
            rvalid_o  = '0;
            rdata_o   = '0;
            err_o     = ErrNone;
            idle_o    = 1'b0;
        end

        // While reset is asserted the outputs show their reset values
        // immediately, even if a port is still holding its request.
        if (!rst_ni) begin
            fwd_en    = 1'b0;
            gnt_o     = '0;
            rvalid_o  = '0;
            rdata_o   = '0;
            err_o     = ErrNone;
            fsm_err_o = 1'b0;
            idle_o    = 1'b1;
        end
    end

    // Forward the selected bundle; a quiet bus reads as a zero Read command
    always_comb begin
        otp_req_o   = fwd_en;
        otp_cmd_o   = CmdRead;
        otp_size_o  = '0;
        otp_wdata_o = '0;
        otp_addr_o  = '0;
        if (fwd_en) begin
            otp_cmd_o   = cmd_i[fwd_sel];
            otp_size_o  = size_i[fwd_sel];
            otp_wdata_o = wdata_i[fwd_sel];
            otp_addr_o  = addr_i[fwd_sel];
        end
    end

    // State, owner and round-robin pointer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: non-blocking assignments here so every register samples the
        // values from before this edge, independent of statement order.
        if (!rst_ni) begin
            state_q <= IdleSt;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_otp_ctrl_prog_arb.sv
// Self-checking bench for otp_ctrl_prog_arb. Expected grants and responses are
// queued when stimulus is driven and popped when the DUT answers.
module tb_otp_ctrl_prog_arb;

    localparam logic [3:0] LcOn  = 4'b0101;
    localparam logic [3:0] LcOff = 4'b1010;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic [3:0]       escalate_en_i;
    logic [1:0]       req_i;
    logic [1:0][2:0]  cmd_i;
    logic [1:0][1:0]  size_i;
    logic [1:0][63:0] wdata_i;
    logic [1:0][9:0]  addr_i;
    logic [1:0]       gnt_o;
    logic [1:0]       rvalid_o;
    logic [63:0]      rdata_o;
    logic [2:0]       err_o;
    logic             otp_req_o;
    logic [2:0]       otp_cmd_o;
    logic [1:0]       otp_size_o;
    logic [63:0]      otp_wdata_o;
    logic [9:0]       otp_addr_o;
    logic             otp_gnt_i;
    logic             otp_rvalid_i;
    logic [63:0]      otp_rdata_i;
    logic [2:0]       otp_err_i;
    logic             fsm_err_o;
    logic             idle_o;

    typedef struct {
        int          port;
        logic [63:0] data;
        logic [2:0]  err;
    } rsp_t;

    rsp_t rsp_q[$];
    int   gnt_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk_i = ~clk_i;

    otp_ctrl_prog_arb dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .escalate_en_i (escalate_en_i),
        .req_i         (req_i),
        .cmd_i         (cmd_i),
        .size_i        (size_i),
        .wdata_i       (wdata_i),
        .addr_i        (addr_i),
        .gnt_o         (gnt_o),
        .rvalid_o      (rvalid_o),
        .rdata_o       (rdata_o),
        .err_o         (err_o),
        .otp_req_o     (otp_req_o),
        .otp_cmd_o     (otp_cmd_o),
        .otp_size_o    (otp_size_o),
        .otp_wdata_o   (otp_wdata_o),
        .otp_addr_o    (otp_addr_o),
        .otp_gnt_i     (otp_gnt_i),
        .otp_rvalid_i  (otp_rvalid_i),
        .otp_rdata_i   (otp_rdata_i),
        .otp_err_i     (otp_err_i),
        .fsm_err_o     (fsm_err_o),
        .idle_o        (idle_o)
    );

    // One cycle step: inputs are driven 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        escalate_en_i = LcOff;
        req_i         = '0;
        cmd_i         = '0;
        size_i        = '0;
        wdata_i       = '0;
        addr_i        = '0;
        otp_gnt_i     = 1'b0;
        otp_rvalid_i  = 1'b0;
        otp_rdata_i   = '0;
        otp_err_i     = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle_inputs();
        #12;
        n_cmp++; if (gnt_o !== 2'b00) begin n_err++; $display("FAIL reset_gnt: got %b want 00", gnt_o); end
        n_cmp++; if (rvalid_o !== 2'b00) begin n_err++; $display("FAIL reset_rvalid: got %b want 00", rvalid_o); end
        n_cmp++; if (otp_req_o !== 1'b0) begin n_err++; $display("FAIL reset_otp_req: got %b want 0", otp_req_o); end
        n_cmp++; if (otp_cmd_o !== 3'h0) begin n_err++; $display("FAIL reset_otp_cmd: got %h want 0 (Read)", otp_cmd_o); end
        n_cmp++; if (idle_o !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b want 1", idle_o); end
        n_cmp++; if (fsm_err_o !== 1'b0) begin n_err++; $display("FAIL reset_fsm_err: got %b want 0", fsm_err_o); end
        n_cmp++; if (rdata_o !== 64'h0 || err_o !== 3'h0) begin n_err++; $display("FAIL reset_rsp: got rdata %h err %h want 0/0", rdata_o, err_o); end
    endtask

    // Single port-0 write granted immediately, answered three cycles later.
    task automatic test_single();
        rsp_t got;
        apply_reset();
        cyc();
        req_i      = 2'b01;
        addr_i[0]  = 10'h2A0;
        cmd_i[0]   = 3'h1;
        size_i[0]  = 2'd1;
        wdata_i[0] = 64'hDEAD_BEEF_0123_4567;
        addr_i[1]  = 10'h3FF;
        otp_gnt_i  = 1'b1;
        #1;
        n_cmp++; if (gnt_o !== 2'b01) begin n_err++; $display("FAIL single_gnt: got %b want 01", gnt_o); end
        n_cmp++; if (otp_addr_o !== 10'h2A0) begin n_err++; $display("FAIL single_fwd_addr: got %h want 2a0", otp_addr_o); end
        n_cmp++; if ({otp_req_o, otp_cmd_o, otp_size_o} !== {1'b1, 3'h1, 2'd1}) begin n_err++; $display("FAIL single_fwd_ctl: got req %b cmd %h size %h want 1/1/1", otp_req_o, otp_cmd_o, otp_size_o); end
        n_cmp++; if (otp_wdata_o !== 64'hDEAD_BEEF_0123_4567) begin n_err++; $display("FAIL single_fwd_wdata: got %h", otp_wdata_o); end
        cyc();
        req_i     = 2'b00;
        otp_gnt_i = 1'b0;
        #1;
        n_cmp++; if ({otp_req_o, otp_addr_o, otp_wdata_o, otp_cmd_o} !== '0) begin n_err++; $display("FAIL single_quiet_bus: got req %b addr %h wdata %h cmd %h want all 0", otp_req_o, otp_addr_o, otp_wdata_o, otp_cmd_o); end
        cyc();
        #1;
        n_cmp++; if (rvalid_o !== 2'b00 || idle_o !== 1'b0) begin n_err++; $display("FAIL single_wait: got rvalid %b idle %b want 00/0", rvalid_o, idle_o); end
        cyc();
        otp_rvalid_i = 1'b1;
        otp_rdata_i  = 64'h0123_4567_89AB_CDEF;
        otp_err_i    = 3'h0;
        rsp_q.push_back('{0, 64'h0123_4567_89AB_CDEF, 3'h0});
        #1;
        got = rsp_q.pop_front();
        n_cmp++; if (rvalid_o !== 2'(2'b01 << got.port) || rdata_o !== got.data || err_o !== got.err) begin n_err++; $display("FAIL single_rsp: got rvalid %b rdata %h err %h want port %0d rdata %h err %h", rvalid_o, rdata_o, err_o, got.port, got.data, got.err); end
        cyc();
        otp_rvalid_i = 1'b0;
        otp_rdata_i  = '0;
        #1;
        n_cmp++; if (idle_o !== 1'b1 || rdata_o !== 64'h0) begin n_err++; $display("FAIL single_idle_after: got idle %b rdata %h want 1/0", idle_o, rdata_o); end
    endtask

    // Both ports held from reset: grants must strictly alternate 0,1,0,1.
    task automatic test_alternation();
        logic [9:0] port_addr [2];
        int         want_port;
        rsp_t       got;
        port_addr[0] = 10'h011;
        port_addr[1] = 10'h122;
        apply_reset();
        gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(0); gnt_q.push_back(1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            req_i        = 2'b11;
            addr_i[0]    = port_addr[0];
            addr_i[1]    = port_addr[1];
            otp_gnt_i    = 1'b1;
            otp_rvalid_i = 1'b0;
            #1;
            want_port = gnt_q.pop_front();
            n_cmp++; if (gnt_o !== 2'(2'b01 << want_port) || otp_addr_o !== port_addr[want_port]) begin n_err++; $display("FAIL alt_gnt[%0d]: got gnt %b addr %h want port %0d addr %h", k, gnt_o, otp_addr_o, want_port, port_addr[want_port]); end
            cyc();
            otp_gnt_i    = 1'b0;
            otp_rvalid_i = 1'b1;
            otp_rdata_i  = 64'hA5 + 64'(k);
            rsp_q.push_back('{want_port, 64'hA5 + 64'(k), 3'h0});
            #1;
            n_cmp++; if (otp_req_o !== 1'b0) begin n_err++; $display("FAIL alt_req_in_rsp[%0d]: got %b want 0", k, otp_req_o); end
            got = rsp_q.pop_front();
            n_cmp++; if (rvalid_o !== 2'(2'b01 << got.port) || rdata_o !== got.data) begin n_err++; $display("FAIL alt_rsp[%0d]: got rvalid %b rdata %h want port %0d rdata %h", k, rvalid_o, rdata_o, got.port, got.data); end
        end
        cyc();
        req_i        = 2'b00;
        otp_rvalid_i = 1'b0;
    endtask

    // Port 1 waits for a grant while port 0 joins; no re-arbitration allowed.
    task automatic test_hold_no_regrant();
        rsp_t got;
        apply_reset();
        addr_i[0] = 10'h0AA;
        addr_i[1] = 10'h155;
        for (int c = 0; c < 4; c++) begin
            cyc();
            req_i = (c == 0) ? 2'b10 : 2'b11;
            #1;
            n_cmp++; if (otp_addr_o !== 10'h155 || gnt_o !== 2'b00) begin n_err++; $display("FAIL hold_cycle%0d: got addr %h gnt %b want 155/00", c, otp_addr_o, gnt_o); end
        end
        cyc();
        otp_gnt_i = 1'b1;
        #1;
        n_cmp++; if (gnt_o !== 2'b10 || otp_addr_o !== 10'h155) begin n_err++; $display("FAIL hold_gnt: got gnt %b addr %h want 10/155", gnt_o, otp_addr_o); end
        cyc();
        otp_gnt_i    = 1'b0;
        otp_rvalid_i = 1'b1;
        otp_rdata_i  = 64'h1111_2222_3333_4444;
        otp_err_i    = 3'h2;
        rsp_q.push_back('{1, 64'h1111_2222_3333_4444, 3'h2});
        #1;
        got = rsp_q.pop_front();
        n_cmp++; if (rvalid_o !== 2'(2'b01 << got.port) || rdata_o !== got.data || err_o !== got.err) begin n_err++; $display("FAIL hold_rsp: got rvalid %b rdata %h err %h want port %0d rdata %h err %h", rvalid_o, rdata_o, err_o, got.port, got.data, got.err); end
        cyc();
        otp_rvalid_i = 1'b0;
        otp_err_i    = 3'h0;
        req_i        = 2'b01;
        otp_gnt_i    = 1'b1;
        #1;
        n_cmp++; if (gnt_o !== 2'b01 || otp_addr_o !== 10'h0AA) begin n_err++; $display("FAIL hold_next_port0: got gnt %b addr %h want 01/0aa", gnt_o, otp_addr_o); end
        cyc();
        req_i        = 2'b00;
        otp_gnt_i    = 1'b0;
        otp_rvalid_i = 1'b1;
        #1;
        n_cmp++; if (rvalid_o !== 2'b01) begin n_err++; $display("FAIL hold_next_rsp: got %b want 01", rvalid_o); end
        cyc();
        otp_rvalid_i = 1'b0;
    endtask

    // Response with nothing outstanding locks the arbiter in its error state.
    task automatic test_rvalid_in_idle();
        logic [1:0] any_gnt;
        logic       any_req;
        apply_reset();
        cyc();
        otp_rvalid_i = 1'b1;
        otp_rdata_i  = 64'hFF;
        #1;
        n_cmp++; if (fsm_err_o !== 1'b1 || rvalid_o !== 2'b00 || rdata_o !== 64'h0) begin n_err++; $display("FAIL idle_rvalid_err: got fsm_err %b rvalid %b rdata %h want 1/00/0", fsm_err_o, rvalid_o, rdata_o); end
        cyc();
        otp_rvalid_i = 1'b0;
        otp_rdata_i  = '0;
        #1;
        n_cmp++; if (fsm_err_o !== 1'b0 || idle_o !== 1'b0) begin n_err++; $display("FAIL idle_rvalid_pulse: got fsm_err %b idle %b want 0/0", fsm_err_o, idle_o); end
        any_gnt = '0;
        any_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            req_i     = 2'b01;
            otp_gnt_i = 1'b1;
            #1;
            any_gnt |= gnt_o;
            any_req |= otp_req_o;
        end
        n_cmp++; if (any_gnt !== 2'b00 || any_req !== 1'b0) begin n_err++; $display("FAIL error_state_no_gnt: got gnt %b req %b want 00/0", any_gnt, any_req); end
    endtask

    // Owner drops its request before the macro grants it.
    task automatic test_wait_gnt_drop();
        apply_reset();
        cyc();
        req_i = 2'b01;
        #1;
        n_cmp++; if (otp_req_o !== 1'b1) begin n_err++; $display("FAIL drop_fwd: got %b want 1", otp_req_o); end
        cyc();
        req_i = 2'b00;
        #1;
        n_cmp++; if (fsm_err_o !== 1'b1) begin n_err++; $display("FAIL drop_fsm_err: got %b want 1", fsm_err_o); end
        cyc();
        #1;
        n_cmp++; if (fsm_err_o !== 1'b0 || idle_o !== 1'b0) begin n_err++; $display("FAIL drop_error_state: got fsm_err %b idle %b want 0/0", fsm_err_o, idle_o); end
    endtask

    // Escalation during WaitRspSt swallows the coincident response.
    task automatic test_escalation();
        apply_reset();
        cyc();
        req_i     = 2'b01;
        otp_gnt_i = 1'b1;
        #1;
        n_cmp++; if (gnt_o !== 2'b01) begin n_err++; $display("FAIL esc_setup_gnt: got %b want 01", gnt_o); end
        cyc();
        req_i         = 2'b00;
        otp_gnt_i     = 1'b0;
        escalate_en_i = LcOn;
        otp_rvalid_i  = 1'b1;
        otp_rdata_i   = 64'hCAFE;
        #1;
        n_cmp++; if (rvalid_o !== 2'b00 || fsm_err_o !== 1'b1 || rdata_o !== 64'h0) begin n_err++; $display("FAIL esc_rsp: got rvalid %b fsm_err %b rdata %h want 00/1/0", rvalid_o, fsm_err_o, rdata_o); end
        cyc();
        escalate_en_i = LcOff;
        otp_rvalid_i  = 1'b0;
        req_i         = 2'b01;
        otp_gnt_i     = 1'b1;
        #1;
        n_cmp++; if (gnt_o !== 2'b00 || idle_o !== 1'b0 || otp_req_o !== 1'b0) begin n_err++; $display("FAIL esc_terminal: got gnt %b idle %b req %b want 00/0/0", gnt_o, idle_o, otp_req_o); end
        // a non-Off, non-On encoding also counts as escalation
        apply_reset();
        cyc();
        escalate_en_i = 4'b0000;
        #1;
        n_cmp++; if (fsm_err_o !== 1'b1) begin n_err++; $display("FAIL esc_loose_true: got %b want 1", fsm_err_o); end
        cyc();
        escalate_en_i = LcOff;
        #1;
        n_cmp++; if (idle_o !== 1'b0) begin n_err++; $display("FAIL esc_loose_state: got idle %b want 0", idle_o); end
    endtask

    // Reset asserted mid-cycle while waiting for a grant, then a late response.
    task automatic test_async_reset();
        apply_reset();
        cyc();
        req_i     = 2'b10;
        addr_i[1] = 10'h1C3;
        #1;
        n_cmp++; if (otp_req_o !== 1'b1) begin n_err++; $display("FAIL areset_fwd: got %b want 1", otp_req_o); end
        cyc();
        #1;
        n_cmp++; if (otp_addr_o !== 10'h1C3) begin n_err++; $display("FAIL areset_waitgnt_addr: got %h want 1c3", otp_addr_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        n_cmp++; if ({otp_req_o, otp_addr_o, gnt_o, rvalid_o, fsm_err_o} !== '0) begin n_err++; $display("FAIL areset_outputs: got req %b addr %h gnt %b rvalid %b fsm_err %b want all 0", otp_req_o, otp_addr_o, gnt_o, rvalid_o, fsm_err_o); end
        @(negedge clk_i);
        req_i = 2'b00;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        cyc();
        #1;
        n_cmp++; if (idle_o !== 1'b1) begin n_err++; $display("FAIL areset_idle_after: got %b want 1", idle_o); end
        cyc();
        otp_rvalid_i = 1'b1;
        #1;
        n_cmp++; if (fsm_err_o !== 1'b1 || rvalid_o !== 2'b00) begin n_err++; $display("FAIL areset_late_rvalid: got fsm_err %b rvalid %b want 1/00", fsm_err_o, rvalid_o); end
        cyc();
        otp_rvalid_i = 1'b0;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_alternation();
        test_hold_no_regrant();
        test_rvalid_in_idle();
        test_wait_gnt_drop();
        test_escalation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/otp_ctrl_prog_arb.md
OTP_CTRL_PROG_ARB -- requirements
Module: otp_ctrl_prog_arb

Interface
REQ-001 Parameters: none; widths SHALL come from otp_ctrl_pkg/otp_ctrl_reg_pkg (OtpSizeWidth, OtpIfWidth, OtpAddrWidth, ScrmblBlockWidth); port 0 = LCI, port 1 = DAI.
REQ-002 clk_i  in  1  sole clock; one clock domain.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 escalate_en_i  in  lc_tx_t  escalation; loose-true forces ErrorSt.
REQ-005 req_i  in  [2]  per-port OTP request, held until granted.
REQ-006 cmd_i  in  [2] x prim_otp_pkg::cmd_e  per-port command.
REQ-007 size_i  in  [2] x OtpSizeWidth  per-port size.
REQ-008 wdata_i  in  [2] x OtpIfWidth  per-port write data.
REQ-009 addr_i  in  [2] x OtpAddrWidth  per-port halfword address.
REQ-010 gnt_o  out  [2]  per-port grant pulse.
REQ-011 rvalid_o  out  [2]  per-port response valid pulse.
REQ-012 rdata_o  out  ScrmblBlockWidth  shared response data, qualified by rvalid_o.
REQ-013 err_o  out  prim_otp_pkg::err_e  shared response error, qualified by rvalid_o.
REQ-014 otp_req_o/otp_cmd_o/otp_size_o/otp_wdata_o/otp_addr_o  out  macro request bundle.
REQ-015 otp_gnt_i  in  1; otp_rvalid_i  in  1; otp_rdata_i  in  ScrmblBlockWidth; otp_err_i  in  err_e  -- macro response.
REQ-016 fsm_err_o  out  1  pulses on invalid state, escalation or protocol violation.
REQ-017 idle_o  out  1  high only in IdleSt with no request pending.

Function
REQ-018 FSM SHALL be sparse-encoded (min Hamming distance 5) with states IdleSt, WaitGntSt, WaitRspSt, ErrorSt, held in prim sparse-FSM flops; reset state IdleSt.
REQ-019 At most one macro transaction SHALL be outstanding; owner register (1 bit) and round-robin pointer (1 bit, reset 0 = port 0 preferred) SHALL be kept.
REQ-020 IdleSt: any req_i -> winner = sole requester, or on tie the port not equal to last granted owner; winner's bundle SHALL drive otp_* in the same cycle (zero-latency forward).
REQ-021 IdleSt with otp_gnt_i same cycle -> gnt_o[winner]=1, owner<=winner, pointer updated, -> WaitRspSt; without grant -> owner<=winner, -> WaitGntSt.
REQ-022 WaitGntSt: owner's bundle SHALL be forwarded unchanged, no re-arbitration; otp_gnt_i -> gnt_o[owner]=1, -> WaitRspSt.
REQ-023 WaitGntSt with req_i[owner] deasserted -> ErrorSt, fsm_err_o=1.
REQ-024 WaitRspSt: otp_req_o=0; otp_rvalid_i -> rvalid_o[owner]=1 same cycle, rdata_o/err_o = otp_rdata_i/otp_err_i, -> IdleSt; next grant no earlier than following cycle.
REQ-025 otp_rvalid_i in IdleSt or WaitGntSt -> ErrorSt, fsm_err_o=1, response discarded.
REQ-026 rvalid_o and gnt_o SHALL never assert for the non-owner; rdata_o/err_o SHALL be 0 when no rvalid_o.
REQ-027 otp_wdata_o/otp_addr_o/otp_cmd_o/otp_size_o SHALL be 0/Read when otp_req_o=0.
REQ-028 ErrorSt terminal: all gnt_o, rvalid_o, otp_req_o = 0, idle_o=0; exit only by reset.
REQ-029 Escalation (any state) or invalid state encoding -> ErrorSt next cycle, fsm_err_o=1 that cycle; escalation overrides simultaneous gnt/rvalid (no pulse forwarded).

Reset
REQ-030 Reset SHALL clear owner and pointer to 0, state to IdleSt; all outputs 0 except otp_cmd_o=Read, idle_o=1.
REQ-031 Reset mid-transaction SHALL abandon it; any late otp_rvalid_i after reset SHALL be treated per REQ-025.

Verification
REQ-032 req_i=01, addr_i[0]=0x2A0, otp_gnt_i same cycle, rvalid 3 cycles later err=NoError -> gnt_o=01 cycle 0, rvalid_o=01 cycle 3, idle_o=1 cycle 4.
REQ-033 req_i=11 from reset, both held -> port 0 served first, port 1 second; repeat -> port 0 again (strict alternation).
REQ-034 req_i=10, otp_gnt_i withheld 4 cycles, req_i[0] asserted meanwhile -> otp_addr_o stays addr_i[1], gnt_o=10 on cycle 4.
REQ-035 otp_rvalid_i pulsed in IdleSt -> fsm_err_o=1 one cycle, ErrorSt, later req_i=01 never granted.
REQ-036 escalate_en_i=On in WaitRspSt coincident with otp_rvalid_i -> rvalid_o=00, fsm_err_o=1, ErrorSt.
REQ-037 rst_ni low in WaitGntSt -> all outputs at reset values asynchronously, idle_o=1 after release.
